// File: rtl/dcache_wb.sv
// dcache_wb: write-back write-allocate direct-mapped data cache; DCACHE_STATS_EN adds hit/miss counters
module dcache_wb #(
  parameter int SETS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         wen,
  input  logic [63:0]  addr,
  input  logic [63:0]  wdata,
  input  logic [7:0]   wmask,
  output logic [63:0]  rdata,
  output logic         done,
  output logic         drequest,
  output logic         dwrenable,
  output logic [63:0]  daddr,
  output logic [511:0] dwdata,
  input  logic [511:0] drdata,
`ifdef DCACHE_STATS_EN
  input  logic         ddone,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`else
  input  logic         ddone
`endif
);
  localparam int LINE_BYTES = 64;
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 64 - OFF_W - IDX_W;
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, WB = 3'd2, FILL = 3'd3, RESP = 3'd4;
  logic [2:0] state;
  logic st;
  logic [63:3] a;
  logic [63:0] wd;
  logic [7:0] wm;
  logic [TAG_W-1:0] tags [SETS];
  logic [511:0] lines [SETS];
  logic [SETS-1:0] valid, dirty;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0] word;
  logic hit, we;
  logic [511:0] base, merged;
  logic [63:0] rword;
  assign idx = a[OFF_W+IDX_W-1:OFF_W];
  assign tag = a[63:OFF_W+IDX_W];
  assign word = a[5:3];
  assign hit = valid[idx] && tags[idx] == tag;
  assign we = (state == LOOKUP && hit && st) || (state == FILL && ddone);
  // One merge path serves both store hits (resident line) and fills (incoming line)
  always_comb begin
    base = state == LOOKUP ? lines[idx] : drdata;
    merged = base;
    for (int b = 0; b < 8; b++)
      if (st && wm[b]) merged[int'(word)*64 + b*8 +: 8] = wd[b*8 +: 8];
    rword = merged[int'(word)*64 +: 64];
  end
  always_ff @(posedge clk)
    if (we) begin
      lines[idx] <= merged;
      tags[idx] <= tag;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      done <= 1'b0;
      drequest <= 1'b0;
      dwrenable <= 1'b0;
      daddr <= '0;
      dwdata <= '0;
      rdata <= '0;
      st <= 1'b0;
      a <= '0;
      wd <= '0;
      wm <= '0;
    end else begin
      done <= 1'b0;
      drequest <= 1'b0;
      dwrenable <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          st <= wen;
          a <= addr[63:3];
          wd <= wdata;
          wm <= wmask;
          state <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          rdata <= rword;
          if (st) dirty[idx] <= 1'b1;
          state <= RESP;
        end else if (valid[idx] && dirty[idx]) begin
          drequest <= 1'b1;
          dwrenable <= 1'b1;
          daddr <= {tags[idx], idx, 6'b0};
          dwdata <= lines[idx];
          state <= WB;
        end else begin
          drequest <= 1'b1;
          daddr <= {a[63:6], 6'b0};
          state <= FILL;
        end
        WB: if (ddone) begin
          drequest <= 1'b1;
          daddr <= {a[63:6], 6'b0};
          state <= FILL;
        end
        FILL: if (ddone) begin
          valid[idx] <= 1'b1;
          dirty[idx] <= st;
          rdata <= rword;
          state <= RESP;
        end
        RESP: begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hit_count <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit && ~&hit_count) hit_count <= hit_count + 32'd1;
      if (!hit && ~&miss_count) miss_count <= miss_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed plus randomized accesses checked against a line-level cache/memory model
module tb_dcache_wb;
  logic clk = 1'b0;
  logic reset, enable, wen, ddone, done, drequest, dwrenable;
  logic [63:0] addr, wdata, rdata, daddr;
  logic [7:0] wmask;
  logic [511:0] drdata, dwdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  dcache_wb dut (
    .clk(clk), .reset(reset), .enable(enable), .wen(wen), .addr(addr), .wdata(wdata),
    .wmask(wmask), .rdata(rdata), .done(done), .drequest(drequest), .dwrenable(dwrenable),
    .daddr(daddr), .dwdata(dwdata), .drdata(drdata),
`ifdef DCACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .ddone(ddone)
  );
  always #5 clk = ~clk;
  typedef struct {logic we; logic [63:0] a; logic [511:0] d;} req_t;
  req_t exp_q[$];
  logic [511:0] backing [logic [57:0]];
  bit mv [64];
  bit md [64];
  logic [57:0] mline [64];
  logic [511:0] mdata [64];
  int vectors = 0, miscompares = 0, m_hits = 0, m_misses = 0;
  logic [63:0] got;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [511:0] mem_line(input logic [57:0] ln);
    if (!backing.exists(ln)) backing[ln] = rnd_line();
    return backing[ln];
  endfunction

  task automatic model(input bit st, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] wm,
                       output bit hit, output logic [63:0] rd);
    logic [57:0] ln;
    int ix, w;
    ln = a[63:6];
    ix = int'(ln % 64);
    w = int'(a[5:3]);
    hit = mv[ix] && mline[ix] == ln;
    if (hit) m_hits++;
    else begin
      m_misses++;
      if (mv[ix] && md[ix]) begin
        exp_q.push_back('{1'b1, {mline[ix], 6'b0}, mdata[ix]});
        backing[mline[ix]] = mdata[ix];
      end
      exp_q.push_back('{1'b0, {ln, 6'b0}, 512'b0});
      mdata[ix] = mem_line(ln);
      mv[ix] = 1'b1;
      mline[ix] = ln;
      md[ix] = 1'b0;
    end
    if (st) begin
      for (int b = 0; b < 8; b++) if (wm[b]) mdata[ix][w*64 + b*8 +: 8] = wd[b*8 +: 8];
      md[ix] = 1'b1;
    end
    rd = mdata[ix][w*64 +: 64];
  endtask

  task automatic access(input bit st, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] wm,
                        output logic [63:0] res);
    bit hit, fin;
    logic [63:0] er;
    int pend;
    req_t r;
    fin = 1'b0;
    pend = 0;
    r = '{1'b0, 64'b0, 512'b0};
    model(st, a, wd, wm, hit, er);
    @(negedge clk);
    enable = 1'b1; wen = st; addr = a; wdata = wd; wmask = wm;
    @(negedge clk);
    enable = 1'b0; wen = 1'($urandom); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    wmask = 8'($urandom);
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      @(negedge clk);
      ddone = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ddone = 1'b1;
          drdata = r.we ? rnd_line() : mem_line(r.a[63:6]);
        end
      end
      if (drequest) begin
        if (exp_q.size() == 0) chk("unexpected_drequest", 512'(daddr), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        else begin
          r = exp_q.pop_front();
          chk("dwrenable", 512'(dwrenable), 512'(r.we));
          chk("daddr", 512'(daddr), 512'(r.a));
          if (r.we) chk("dwdata", dwdata, r.d);
          pend = 1 + int'($urandom_range(0, 3));
        end
      end
      if (done) begin
        fin = 1'b1;
        if (hit) chk("hit_latency", 512'(cyc), 512'(2));
      end
    end
    ddone = 1'b0;
    chk("done_seen", 512'(fin), 512'(1));
    chk("requests_left", 512'(exp_q.size()), 512'(0));
    if (!st) chk("rdata", 512'(rdata), 512'(er));
    res = rdata;
    exp_q.delete();
    @(negedge clk);
    chk("done_pulse", 512'(done), 512'(0));
  endtask

  initial begin
    logic [511:0] l;
    bit seen;
    reset = 1'b1; enable = 1'b0; wen = 1'b0; addr = '0; wdata = '0; wmask = '0;
    ddone = 1'b0; drdata = '0;
    l = rnd_line();
    l[63:0] = 64'hAAAA_AAAA_AAAA_AAAA;
    l[127:64] = 64'hBBBB_BBBB_BBBB_BBBB;
    backing[58'h40] = l;
    repeat (3) @(negedge clk);
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_drequest", 512'(drequest), 512'(0));
    chk("rst_dwrenable", 512'(dwrenable), 512'(0));
    chk("rst_daddr", 512'(daddr), 512'(0));
    chk("rst_dwdata", dwdata, 512'(0));
    chk("rst_rdata", 512'(rdata), 512'(0));
`ifdef DCACHE_STATS_EN
    chk("rst_hits", 512'(hit_count), 512'(0));
    chk("rst_misses", 512'(miss_count), 512'(0));
`endif
    reset = 1'b0;
    access(1'b0, 64'h1000, 64'h0, 8'h0, got);
    chk("tp_load_miss", 512'(got), 512'(64'hAAAA_AAAA_AAAA_AAAA));
    access(1'b0, 64'h1004, 64'h0, 8'h0, got);
    chk("tp_load_hit", 512'(got), 512'(64'hAAAA_AAAA_AAAA_AAAA));
    access(1'b1, 64'h1008, 64'h1122_3344_5566_7788, 8'h0F, got);
    access(1'b0, 64'h1008, 64'h0, 8'h0, got);
    chk("tp_merge", 512'(got), 512'(64'hBBBB_BBBB_5566_7788));
    access(1'b0, 64'h2000, 64'h0, 8'h0, got);
    chk("tp_wb_backing", 512'(backing[58'h40][127:64]), 512'(64'hBBBB_BBBB_5566_7788));
    access(1'b1, 64'h3010, 64'hDEAD_BEEF_0123_4567, 8'hFF, got);
    access(1'b0, 64'h3010, 64'h0, 8'h0, got);
    chk("tp_store_alloc", 512'(got), 512'(64'hDEAD_BEEF_0123_4567));
    access(1'b1, 64'h1000, 64'h5555_6666_7777_8888, 8'h00, got);
    // Reset while a fill is outstanding, then a stray ddone
    @(negedge clk);
    enable = 1'b1; wen = 1'b0; addr = 64'h1040;
    @(negedge clk);
    enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = drequest;
    end
    chk("rf_req_seen", 512'(seen), 512'(1));
    chk("rf_req_addr", 512'(daddr), 512'(64'h1040));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rf_drequest", 512'(drequest), 512'(0));
    chk("rf_daddr", 512'(daddr), 512'(0));
    @(negedge clk);
    reset = 1'b0; ddone = 1'b1; drdata = rnd_line();
    @(negedge clk);
    ddone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rf_no_done", 512'(done), 512'(0));
      chk("rf_no_req", 512'(drequest), 512'(0));
    end
    for (int i = 0; i < 64; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
    access(1'b0, 64'h1000, 64'h0, 8'h0, got);
    for (int n = 0; n < 200; n++) begin
      logic [63:0] ra;
      logic [7:0] rm;
      ra = {50'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 3'($urandom), 3'($urandom)} << 3;
      ra = ra >> 3;
      ra = {ra[63:12], ra[11:0]};
      ra = (64'($urandom_range(0, 3)) << 12) | (64'($urandom_range(0, 3)) << 6) | 64'($urandom_range(0, 63));
      rm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      access(1'($urandom), ra, {$urandom, $urandom}, rm, got);
    end
`ifdef DCACHE_STATS_EN
    chk("hit_count", 512'(hit_count), 512'(m_hits));
    chk("miss_count", 512'(miss_count), 512'(m_misses));
    reset = 1'b1;
    #1;
    chk("hits_cleared", 512'(hit_count), 512'(0));
    chk("misses_cleared", 512'(miss_count), 512'(0));
    @(negedge clk);
    reset = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dcache_wb.md
# dcache_wb

Parametrised write-back, write-allocate, direct-mapped data cache between the core's load/store unit and the 512-bit line-granular memory port. Serves 64-bit word accesses with per-byte write masks from on-chip storage. Goes to memory only on a miss: a dirty-victim writeback if needed, then a line fill. Successor to the uncached read-modify-write data path; memory-side handshake is unchanged.

## Interface
- SETS, 64, number of lines; power of two, 4..1024; IDX_W = log2(SETS).
- LINE_BYTES, 64, fixed by the 512-bit memory port; not overridable.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears state, valid and dirty bits, outputs.
- enable  in  1  request strobe; sampled only in IDLE.
- wen  in  1  1 = store, 0 = load.
- addr  in  64  byte address; addr[2:0] ignored (word-aligned by truncation).
- wdata  in  64  store data.
- wmask  in  8  store byte enables; bit i covers wdata[8i+7:8i].
- rdata  out  64  load data; valid with done, held until the next done.
- done  out  1  one-cycle completion pulse for loads and stores.
- drequest  out  1  one-cycle memory request pulse.
- dwrenable  out  1  qualifies drequest: 1 = line write, 0 = line read.
- daddr  out  64  line address, addr[5:0]=0; held until ddone.
- dwdata  out  512  victim line for writeback; held until ddone.
- drdata  in  512  fill data; valid when ddone=1.
- ddone  in  1  memory completion pulse.

## Operation
- Address split: word = addr[5:3]; index = addr[6+IDX_W-1:6]; tag = addr[63:6+IDX_W].
- Per set: valid, dirty, tag, and 512-bit data. Only valid and dirty are reset.
- IDLE: on enable, latch wen, addr, wdata and wmask, then go to LOOKUP. enable in any other state is ignored and is not queued.
- LOOKUP: a hit is valid && tag match.
  - Load hit: rdata = the selected word, then RESP.
  - Store hit: merge the wmask bytes into the word, set dirty, then RESP.
  - Miss with a clean or invalid victim: go to FILL.
  - Miss with a dirty victim: go to WB.
- WB: pulse drequest=1 and dwrenable=1 for one cycle. daddr = {victim tag, index, 6'b0}; dwdata = the victim line. Wait for ddone, then go to FILL.
- FILL: pulse drequest=1 and dwrenable=0 for one cycle, with daddr = {addr[63:6], 6'b0}. Wait for ddone.
- On ddone in FILL:
  - Install drdata, set valid, write the tag.
  - A store merges its wdata bytes into the filled line and sets dirty; a load clears dirty.
  - rdata is taken from the merged line; go to RESP.
- RESP: done=1 for one cycle, then return to IDLE.
- A store with wmask=0 still allocates the line and sets dirty.
- ddone is ignored outside WB and FILL.

## Timing
- Reset values: done=0, drequest=0, dwrenable=0, daddr=0, dwdata=0, rdata=0, state IDLE.
- Hit latency: enable sampled at edge N; done=1 in the cycle after edge N+2.
- Miss latency: done=1 in the cycle after the edge that sampled the final ddone plus one cycle. Memory latency is arbitrary, including ddone in the cycle right after drequest.
- daddr and dwdata change only when a new drequest is issued or at reset.
- Reset in mid-transaction:
  - Immediately returns to IDLE, drops drequest/dwrenable/done, and invalidates all lines; dirty data is lost.
  - A late ddone is ignored.
- A new request may be accepted in the cycle after done; back-to-back hits sustain one access per 3 cycles.

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_count and miss_count (32 bits each).
  - Each counter increments once per access at the LOOKUP decision.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then load 0x1000; memory returns word0=0xAAAA_AAAA_AAAA_AAAA -> one drequest with daddr=0x1000, dwrenable=0, and done with that rdata. Reload 0x1004 -> done 2 cycles after enable, same rdata, no drequest.
- Store 0x1008 with wdata=0x1122334455667788 and wmask=0x0F on the resident line whose word1 is 0xBBBB_BBBB_BBBB_BBBB -> no memory traffic. A following load of 0x1008 returns 0xBBBBBBBB55667788.
- Load 0x2000, which maps to the same index, with line 0x1000 dirty (SETS=64):
  - a writeback first: daddr=0x1000, dwrenable=1, dwdata word1 = 0xBBBBBBBB55667788;
  - after ddone, a fill with daddr=0x2000;
  - done only after the second ddone.
- Store miss to 0x3010 with wmask=0xFF -> a fill only (clean victim), the line becomes dirty, and a later load of 0x3010 returns the stored wdata.
- Assert reset while waiting in FILL, then pulse ddone -> no done. A load of 0x1000 then misses and issues drequest.
- With DCACHE_STATS_EN: sequence miss, hit, hit, miss -> hit_count=2, miss_count=2; reset -> both 0.
